// File: rtl/ysyx_23060184_exu_seq_pkg.sv
// Shared execute-stage definitions: sequencer state encodings and
// the operand/control field widths used by the EXU datapath registers.
package ysyx_23060184_exu_seq_pkg;

  localparam int ALU_OP_LENGTH = 4;
  localparam int PC_SRC_LENGTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } exu_state_e;

endpackage

// File: rtl/ysyx_23060184_exu_seq.sv
// Execute-stage sequencer between IDU and EXU. It hands out one-cycle
// capture enables for operands (OpLatch) and results (ResLatch), counts
// down multi-cycle ops, and holds Evalid until memory takes the result.
module ysyx_23060184_exu_seq
  import ysyx_23060184_exu_seq_pkg::*;
#(
  parameter int LAT_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Dvalid,
  input  logic [LAT_W-1:0] OpLat,
  input  logic             Mready,
  input  logic             Flush,
  output logic             Eready,
  output logic             Evalid,
  output logic             OpLatch,
  output logic             ResLatch,
  output logic             Busy,
  output logic [CNT_W-1:0] RetireCnt
);

  exu_state_e       r_state;
  exu_state_e       w_state_nxt;
  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_retire_cnt;

  logic w_eready;
  logic w_accept;
  logic w_retire;
  logic w_lat_zero;
  logic w_cnt_last;

  // A new op can enter when idle, or when the finished result leaves
  // this same cycle, which gives back-to-back issue without a bubble.
  assign w_eready   = (r_state == IDLE) | ((r_state == DONE) & Mready);
  assign w_accept   = Dvalid & w_eready & ~Flush;
  assign w_lat_zero = (OpLat == '0);
  assign w_cnt_last = (r_cnt == LAT_W'(1));

  // A flushed result is never presented, so it can never be retired.
  assign Evalid    = (r_state == DONE) & ~Flush;
  assign w_retire  = Evalid & Mready;

  assign Eready    = w_eready;
  assign OpLatch   = w_accept;
  assign Busy      = (r_state != IDLE);
  assign RetireCnt = r_retire_cnt;

  // Next-state, countdown and result-capture decode; Flush overrides all.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    ResLatch    = 1'b0;
    if (w_accept) begin
      w_cnt_nxt = OpLat;
      if (w_lat_zero) begin
        ResLatch    = 1'b1;
        w_state_nxt = DONE;
      end else begin
        w_state_nxt = EXEC;
      end
    end else begin
      case (r_state)
        EXEC: begin
          w_cnt_nxt = r_cnt - LAT_W'(1);
          if (w_cnt_last) begin
            ResLatch    = 1'b1;
            w_state_nxt = DONE;
          end
        end
        DONE: begin
          if (Mready) begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
    if (Flush) begin
      ResLatch    = 1'b0;
      w_state_nxt = IDLE;
    end
  end

  // State, countdown and retire counter; reset wins over Flush and Dvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_exu_seq.sv
// Cycle-by-cycle vector bench for the execute sequencer. Each record holds
// the inputs for one cycle and the hand-derived outputs for that cycle.
module tb_ysyx_23060184_exu_seq;

  localparam int LAT_W = 4;
  localparam int CNT_W = 32;

  typedef struct {
    logic             rst;
    logic             dv;
    logic [LAT_W-1:0] lat;
    logic             mr;
    logic             fl;
    logic             er;
    logic             ev;
    logic             ol;
    logic             rl;
    logic             bz;
    logic [CNT_W-1:0] rc;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             Dvalid;
  logic [LAT_W-1:0] OpLat;
  logic             Mready;
  logic             Flush;
  logic             Eready;
  logic             Evalid;
  logic             OpLatch;
  logic             ResLatch;
  logic             Busy;
  logic [CNT_W-1:0] RetireCnt;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl[$];
  vec_t sb[$];

  ysyx_23060184_exu_seq #(.LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .Dvalid   (Dvalid),
    .OpLat    (OpLat),
    .Mready   (Mready),
    .Flush    (Flush),
    .Eready   (Eready),
    .Evalid   (Evalid),
    .OpLatch  (OpLatch),
    .ResLatch (ResLatch),
    .Busy     (Busy),
    .RetireCnt(RetireCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic d, input int l, input logic m,
                              input logic f, input logic er, input logic ev, input logic ol,
                              input logic rl, input logic bz, input logic [CNT_W-1:0] rc);
    vec_t v;
    v.rst = r;  v.dv = d;  v.lat = LAT_W'(l); v.mr = m;  v.fl = f;
    v.er  = er; v.ev = ev; v.ol  = ol;        v.rl = rl; v.bz = bz; v.rc = rc;
    return v;
  endfunction

  // Drive one cycle's inputs just after the rising edge, queue the
  // expected outputs, then compare on the falling edge.
  task automatic step(input vec_t v, input string name);
    vec_t e;
    @(posedge clk);
    #1;
    rst = v.rst; Dvalid = v.dv; OpLat = v.lat; Mready = v.mr; Flush = v.fl;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({Eready, Evalid, OpLatch, ResLatch, Busy, RetireCnt} !==
        {e.er, e.ev, e.ol, e.rl, e.bz, e.rc}) begin
      n_errors++;
      $display("FAIL %s: got er=%b ev=%b ol=%b rl=%b bz=%b rc=%0h, want er=%b ev=%b ol=%b rl=%b bz=%b rc=%0h",
               name, Eready, Evalid, OpLatch, ResLatch, Busy, RetireCnt,
               e.er, e.ev, e.ol, e.rl, e.bz, e.rc);
    end
  endtask

  initial begin
    //            rst dv lat mr fl | er ev ol rl bz rc
    // reset state
    tbl.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
    // single-cycle op, immediate retire
    tbl.push_back(mk(0, 1, 0, 1, 0,   1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,   1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1));
    // OpLat=3, Dvalid ignored while executing
    tbl.push_back(mk(0, 1, 3, 1, 0,   1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0,   0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0,   0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0,   0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0,   1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2));
    // memory stall: Evalid held six cycles, one retire
    tbl.push_back(mk(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 2));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 1, 0,   1, 1, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 3));
    // reset, then four back-to-back single-cycle ops
    tbl.push_back(mk(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 1, 0,   1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0,   1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0,   1, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0,   1, 1, 1, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 1, 0,   1, 1, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 4));
    // Flush in EXEC together with Dvalid
    tbl.push_back(mk(0, 1, 5, 1, 0,   1, 0, 1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 4));
    tbl.push_back(mk(0, 1, 0, 1, 1,   0, 0, 0, 0, 1, 4));
    tbl.push_back(mk(0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 4));
    // Flush in DONE with Mready: no retire
    tbl.push_back(mk(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 4));
    tbl.push_back(mk(0, 1, 0, 1, 1,   1, 0, 0, 0, 1, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 4));
    // Flush in IDLE beats Dvalid
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 4));
    // OpLat=1
    tbl.push_back(mk(0, 1, 1, 1, 0,   1, 0, 1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 1, 0,   0, 0, 0, 1, 1, 4));
    tbl.push_back(mk(0, 0, 0, 1, 0,   1, 1, 0, 0, 1, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 5));
    // back-to-back from DONE into a multi-cycle op
    tbl.push_back(mk(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 5));
    tbl.push_back(mk(0, 1, 2, 1, 0,   1, 1, 1, 0, 1, 5));
    tbl.push_back(mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 6));
    tbl.push_back(mk(0, 0, 0, 1, 0,   0, 0, 0, 1, 1, 6));
    tbl.push_back(mk(0, 0, 0, 1, 0,   1, 1, 0, 0, 1, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 7));
    // reset mid-EXEC aborts the op
    tbl.push_back(mk(0, 1, 4, 0, 0,   1, 0, 1, 0, 0, 7));
    tbl.push_back(mk(1, 0, 0, 1, 0,   0, 0, 0, 0, 1, 7));
    tbl.push_back(mk(0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0));

    rst = 1'b1; Dvalid = 1'b0; OpLat = '0; Mready = 1'b0; Flush = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Counter wrap: preload all-ones, then retire one op
    force dut.r_retire_cnt = {CNT_W{1'b1}};
    #1;
    release dut.r_retire_cnt;
    step(mk(0, 1, 0, 0, 0, 1, 0, 1, 1, 0, {CNT_W{1'b1}}), "wrap_accept");
    step(mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 1, {CNT_W{1'b1}}), "wrap_retire");
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, '0),            "wrap_zero");

    // Reset while DONE with Mready high: Evalid drops, nothing retired
    step(mk(0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0), "rstdone_accept");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), "rstdone_hold");
    step(mk(1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0), "rstdone_rst");
    step(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), "rstdone_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_exu_seq.md
YSYX_23060184_EXU_SEQ -- requirements
Module: ysyx_23060184_exu_seq

Interface
REQ-001 SHALL have parameter LAT_W, default 4, meaning width of the per-op latency field.
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of the retired-op counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port Dvalid, input, 1, meaning the decode stage offers an op.
REQ-006 SHALL have port OpLat, input, LAT_W, meaning extra execute cycles for the offered op (0 = single-cycle ALU op).
REQ-007 SHALL have port Mready, input, 1, meaning the memory stage accepts a result.
REQ-008 SHALL have port Flush, input, 1, meaning redirect: kill the in-flight op.
REQ-009 SHALL have port Eready, output, 1, meaning the sequencer accepts an op this cycle.
REQ-010 SHALL have port Evalid, output, 1, meaning the execute result is valid toward memory.
REQ-011 SHALL have port OpLatch, output, 1, meaning a one-cycle enable to capture operands/ALUOp.
REQ-012 SHALL have port ResLatch, output, 1, meaning a one-cycle enable to capture ALUResult/PCTarget/PCSrc.
REQ-013 SHALL have port Busy, output, 1, meaning the FSM is not IDLE.
REQ-014 SHALL have port RetireCnt, output, CNT_W, meaning the count of completed Evalid&Mready handshakes.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-016 SHALL define accept = Dvalid & Eready & ~Flush, and Eready = (state==IDLE) | (state==DONE & Mready).
REQ-017 SHALL, on accept, pulse OpLatch in the same cycle and load the countdown counter with OpLat.
REQ-018 SHALL, on accept with OpLat==0, go to DONE next cycle and pulse ResLatch in the accept cycle (1-cycle latency).
REQ-019 SHALL, on accept with OpLat>0, go to EXEC; EXEC decrements the counter each cycle; ResLatch pulses and the state moves to DONE in the cycle the counter equals 1 (Evalid after OpLat+1 cycles).
REQ-020 SHALL assert Evalid only in DONE and hold it, with results stable, until Mready.
REQ-021 SHALL, in DONE with Mready and no accept, return to IDLE; with accept in the same cycle, take the new op back-to-back per REQ-018/019 (no bubble).
REQ-022 SHALL increment RetireCnt by 1 on each Evalid & Mready cycle; it wraps modulo 2^CNT_W.
REQ-023 SHALL, on Flush in any state, go to IDLE next cycle; Evalid, OpLatch and ResLatch are deasserted that cycle; RetireCnt does not increment even if Mready is high.
REQ-024 SHALL not accept while Flush is high (Flush has priority over Dvalid).
REQ-025 SHALL ignore Dvalid and OpLat in EXEC (Eready=0).
REQ-026 SHALL drive Busy = (state != IDLE).

Reset
REQ-027 SHALL, on rst high at a clock edge, set state IDLE, counter 0, RetireCnt 0; outputs after reset: Eready=1, Evalid=0, OpLatch=0, ResLatch=0, Busy=0.
REQ-028 SHALL abort any op on mid-operation reset, with no retire counted; rst has priority over Flush and Dvalid.

Structure
REQ-029 SHALL take its state encodings (IDLE/EXEC/DONE) from the shared project defines/package, beside the ALU_OP_LENGTH and PC_SRC_LENGTH constants.
REQ-030 SHALL be a single module without sub-modules; the countdown counter is inline.
REQ-031 SHALL sit between IDU and EXU; EXU registers are enabled by OpLatch/ResLatch.

Verification
REQ-032 SHALL cover: reset, then Dvalid=1, OpLat=0, Mready=1 -> OpLatch and ResLatch at cycle 0, Evalid at cycle 1, RetireCnt=1 at cycle 2.
REQ-033 SHALL cover: OpLat=3, Mready=1 -> Eready=0 for cycles 1-3, ResLatch at cycle 3, Evalid at cycle 4.
REQ-034 SHALL cover: DONE with Mready=0 for 5 cycles, then 1 -> Evalid held 6 cycles, single retire.
REQ-035 SHALL cover: DONE, Mready=1, Dvalid=1, OpLat=0 on every cycle for 4 ops -> Evalid continuous, RetireCnt=4, no bubble.
REQ-036 SHALL cover: Flush during EXEC (OpLat=5, cycle 2) together with Dvalid=1 -> IDLE next cycle, no accept, no ResLatch, RetireCnt unchanged.
REQ-037 SHALL cover: RetireCnt preloaded via force to all-ones, then one retire -> 0; rst during DONE -> Evalid=0 next cycle.
